// File: rtl/key_pkg.sv
// key_pkg
//   Shared types and default parameter values for the multi-key debouncer.
//   key_state_t : per-channel debounce state
//                   KS_REL   released (committed)
//                   KS_P_CHK counting ticks towards a press
//                   KS_PRS   pressed (committed)
//                   KS_R_CHK counting ticks towards a release
package key_pkg;

    typedef enum logic [1:0] {
        KS_REL   = 2'd0,
        KS_P_CHK = 2'd1,
        KS_PRS   = 2'd2,
        KS_R_CHK = 2'd3
    } key_state_t;

    localparam int KEY_N_KEYS_DEF     = 4;
    localparam int KEY_SCAN_DIV_DEF   = 20000;
    localparam int KEY_STABLE_CNT_DEF = 3;
    localparam int KEY_ACTIVE_LOW_DEF = 1;
    localparam int KEY_LONG_TICKS_DEF = 100;

endpackage : key_pkg

// File: rtl/key_debounce_ch.sv
// key_debounce_ch
//   One debounce channel. Counts consecutive scan ticks at a new raw level
//   and commits the level once STABLE_CNT ticks agree.
//   Optional feature macro: KEY_LONGPRESS_EN (adds hold counter and
//   long_press pulse output).
// Ports
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   tick        in   shared scan tick, one clk cycle wide
//   raw         in   synchronised key bit, 1 = pressed
//   level       out  debounced level, 1 = pressed
//   press       out  1-cycle pulse on committed press
//   key_release out  1-cycle pulse on committed release
//                    (named so because "release" is a reserved word)
//   long_press  out  1-cycle pulse after LONG_TICKS ticks held
//                    (only with KEY_LONGPRESS_EN)
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int STABLE_CNT = KEY_STABLE_CNT_DEF,
    parameter int LONG_TICKS = KEY_LONG_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
`ifdef KEY_LONGPRESS_EN
    output logic long_press,
`endif
    output logic key_release
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_sat;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Saturating increment: the stability counter never wraps.
    assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            case (state_q)
                KS_REL: begin
                    if (raw) begin
                        if (STABLE_CNT == 1) begin
                            state_d = KS_PRS;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = KS_P_CHK;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                KS_P_CHK: begin
                    if (raw) begin
                        if (cnt_sat == CNT_MAX) begin
                            state_d = KS_PRS;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_sat;
                        end
                    end else begin
                        // Bounce: back to released without any pulse.
                        state_d = KS_REL;
                        cnt_d   = '0;
                    end
                end
                KS_PRS: begin
                    if (!raw) begin
                        if (STABLE_CNT == 1) begin
                            state_d   = KS_REL;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            state_d = KS_R_CHK;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                KS_R_CHK: begin
                    if (!raw) begin
                        if (cnt_sat == CNT_MAX) begin
                            state_d   = KS_REL;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_sat;
                        end
                    end else begin
                        state_d = KS_PRS;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = KS_REL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= KS_REL;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level       = level_q;
    assign press       = press_q;
    assign key_release = release_q;

`ifdef KEY_LONGPRESS_EN
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_inc;
    logic              long_q, long_d;

    assign hold_inc = hold_q + HOLD_W'(1);

    // The hold counter survives an R_CHK->PRS bounce and only clears once
    // the channel is back in REL, so a bouncy hold still yields one pulse.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_d == KS_REL) begin
            hold_d = '0;
        end else if (tick && state_q == KS_PRS && hold_q != HOLD_MAX) begin
            hold_d = hold_inc;
            long_d = (hold_inc == HOLD_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`endif

endmodule : key_debounce_ch

// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   N-channel push-button conditioner: 2-FF synchroniser per key, one
//   scan-tick prescaler shared by all channels, and one debounce FSM per key.
//   Optional feature macro: KEY_LONGPRESS_EN (adds long_press output).
// Ports
//   clk         in   clock (single domain)
//   reset       in   synchronous active-high reset
//   key         in   [N_KEYS] raw asynchronous key pins
//   level       out  [N_KEYS] debounced level, 1 = pressed
//   press       out  [N_KEYS] 1-cycle pulse on committed press
//   key_release out  [N_KEYS] 1-cycle pulse on committed release
//                    ("release" itself is a reserved word)
//   long_press  out  [N_KEYS] 1-cycle long-hold pulse (KEY_LONGPRESS_EN only)
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N_KEYS     = KEY_N_KEYS_DEF,
    parameter int SCAN_DIV   = KEY_SCAN_DIV_DEF,
    parameter int STABLE_CNT = KEY_STABLE_CNT_DEF,
    parameter int ACTIVE_LOW = KEY_ACTIVE_LOW_DEF,
    parameter int LONG_TICKS = KEY_LONG_TICKS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press,
`ifdef KEY_LONGPRESS_EN
    output logic [N_KEYS-1:0] long_press,
`endif
    output logic [N_KEYS-1:0] key_release
);

    // Elaboration-time parameter range guards.
    if (N_KEYS < 1 || N_KEYS > 16) begin : g_bad_n_keys
        $error("N_KEYS out of range 1..16");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("SCAN_DIV must be >= 2");
    end
    if (STABLE_CNT < 1 || STABLE_CNT > 15) begin : g_bad_stable_cnt
        $error("STABLE_CNT out of range 1..15");
    end
    if (LONG_TICKS < 1) begin : g_bad_long_ticks
        $error("LONG_TICKS must be >= 1");
    end

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    // Pin value of a key that is not pressed.
    localparam logic [N_KEYS-1:0] KEY_IDLE = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : '0;

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic              tick;
    logic [N_KEYS-1:0] key_meta_q, key_meta_d;
    logic [N_KEYS-1:0] key_sync_q, key_sync_d;
    logic [N_KEYS-1:0] raw;

    assign tick = (presc_q == PRE_LAST);

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PRE_W'(1);
        key_meta_d = key;
        key_sync_d = key_meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            key_meta_q <= KEY_IDLE;
            key_sync_q <= KEY_IDLE;
        end else begin
            presc_q    <= presc_d;
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
        end
    end

    // Normalise polarity so every channel sees 1 = pressed.
    assign raw = key_sync_q ^ KEY_IDLE;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .STABLE_CNT (STABLE_CNT),
            .LONG_TICKS (LONG_TICKS)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .raw         (raw[gi]),
            .level       (level[gi]),
            .press       (press[gi]),
`ifdef KEY_LONGPRESS_EN
            .long_press  (long_press[gi]),
`endif
            .key_release (key_release[gi])
        );
    end

endmodule : key_debounce_multi

// File: tb/tb_key_debounce_multi.sv
module tb_key_debounce_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] key_release;
`ifdef KEY_LONGPRESS_EN
    logic [3:0] long_press;
`endif

    key_debounce_multi #(
        .N_KEYS     (4),
        .SCAN_DIV   (4),
        .STABLE_CNT (3),
        .ACTIVE_LOW (1),
        .LONG_TICKS (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key         (key),
        .level       (level),
        .press       (press),
`ifdef KEY_LONGPRESS_EN
        .long_press  (long_press),
`endif
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    // Edge index since the last edge that sampled reset=1 (that edge is 0).
    int edge_cnt = 0;
    always @(posedge clk) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [3:0] p;
        logic [3:0] r;
        int         e;
    } ev_t;

    ev_t exp_q[$];
    int  long_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Expected commit edge for a pin change first sampled at edge e:
    // sync needs edges e and e+1, the FSM updates on edges that are
    // multiples of 4 (SCAN_DIV=4), and the 3rd agreeing tick commits.
    function automatic int commit_edge(input int e);
        int f;
        f = e + 2;
        while (f % 4 != 0) f++;
        return f + 8;
    endfunction

    // Called right after driving key at a negedge.
    task automatic expect_ev(input logic [3:0] p, input logic [3:0] r);
        ev_t x;
        x.p = p;
        x.r = r;
        x.e = commit_edge(edge_cnt + 1);
        exp_q.push_back(x);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: pops one expectation per observed pulse.
    always @(negedge clk) begin
        ev_t x;
        if (!reset && (press != 4'h0 || key_release != 4'h0)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {24'h0, press, key_release}, 32'h0);
            end else begin
                x = exp_q.pop_front();
                $display("event edge=%0d press=%h release=%h level=%h", edge_cnt, press, key_release, level);
                chk("press_mask", press, x.p);
                chk("release_mask", key_release, x.r);
                chk("commit_edge", edge_cnt, x.e);
                chk("level_at_pulse", level & (x.p | x.r), x.p);
            end
        end
`ifdef KEY_LONGPRESS_EN
        if (!reset && long_press != 4'h0) begin
            if (long_q.size() == 0) begin
                chk("unexpected_long", long_press, 4'h0);
            end else begin
                $display("long_press edge=%0d mask=%h", edge_cnt, long_press);
                chk("long_mask", long_press, 4'h1);
                chk("long_edge", edge_cnt, long_q.pop_front());
            end
        end
`endif
    end

    initial begin
        // 1. Reset with all keys released (pins high).
        key   = 4'hF;
        reset = 1'b1;
        cyc(3);
        chk("reset_level", level, 4'h0);
        chk("reset_press", press, 4'h0);
        chk("reset_release", key_release, 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("tick_phase", dut.tick, (edge_cnt % 4) == 3);
        end

        // 2. key[0] held low -> single press pulse on the 3rd tick.
        key[0] = 1'b0;
        expect_ev(4'h1, 4'h0);
        cyc(24);
        chk("t2_level", level, 4'h1);
        chk("t2_queue_empty", exp_q.size(), 0);

        // 3. key[1] low for only 2 ticks -> rejected.
        key[1] = 1'b0;
        cyc(8);
        key[1] = 1'b1;
        cyc(24);
        chk("t3_level", level, 4'h1);
        chk("t3_queue_empty", exp_q.size(), 0);

        // 4. key[2], key[3] together -> joint press and joint release.
        key[3:2] = 2'b00;
        expect_ev(4'hC, 4'h0);
        cyc(32);
        chk("t4_level_pressed", level, 4'hD);
        key[3:2] = 2'b11;
        expect_ev(4'h0, 4'hC);
        cyc(24);
        chk("t4_level_after", level, 4'h1);
        key[0] = 1'b1;
        expect_ev(4'h0, 4'h1);
        cyc(24);
        chk("t4_all_released", level, 4'h0);
        chk("t4_queue_empty", exp_q.size(), 0);

        // 5. Reset during P_CHK of key[0]: nothing emitted, restart from REL.
        key[0] = 1'b0;
        cyc(8);
        chk("t5_pending_level", level, 4'h0);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        chk("t5_post_reset_level", level, 4'h0);
        chk("t5_post_reset_press", press, 4'h0);
        expect_ev(4'h1, 4'h0);
        cyc(24);
        chk("t5_level", level, 4'h1);
        key[0] = 1'b1;
        expect_ev(4'h0, 4'h1);
        cyc(24);
        chk("t5_level_released", level, 4'h0);
        chk("t5_queue_empty", exp_q.size(), 0);

`ifdef KEY_LONGPRESS_EN
        // 6. Long hold twice: one long pulse each time (counter cleared on release).
        for (int r = 0; r < 2; r++) begin
            key[0] = 1'b0;
            expect_ev(4'h1, 4'h0);
            long_q.push_back(exp_q[exp_q.size() - 1].e + 20);
            cyc(44);
            key[0] = 1'b1;
            expect_ev(4'h0, 4'h1);
            cyc(24);
            chk("t6_long_queue_empty", long_q.size(), 0);
        end
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_key_debounce_multi
